// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding and the
// clocks-per-bit helper used to size the baud counter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Integer-MHz clock divided by the line rate, truncated.
    function automatic int clks_per_bit(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full and a pop while
// empty are ignored; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy bookkeeping; push+pop together keeps level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: store strobes fill a byte FIFO, the FSM
// drains it into 8N1/8N2 frames (8E1/8E2 when UART_TX_PARITY_EN is defined).
// Overflowing writes are dropped and latch a sticky flag until cleared.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CLK_FRE    = 27,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [XLEN-1:0]                   wr_data,
    input  logic                              clr_ovf,
    output logic                              tx_pin,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              busy,
    output logic                              ovf
);

    localparam int CPB       = clks_per_bit(CLK_FRE, BAUD_RATE);
    localparam int STOP_CLKS = STOP_BITS * CPB;
    localparam int CNT_W     = $clog2(STOP_CLKS + 1);

    uart_state_e      state_q;
    logic             tx_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shreg_q;
    logic             ovf_q;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
`endif

    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_dout;
    logic       push, pop;
    logic       bit_end, stop_end;
    logic       unused_wr_hi;

    // Only the low byte of the store is transmitted.
    assign unused_wr_hi = ^wr_data[XLEN-1:8];

    assign push     = wr_en & ~fifo_full;
    assign bit_end  = (baud_q == CNT_W'(CPB - 1));
    assign stop_end = (baud_q == CNT_W'(STOP_CLKS - 1));

    // Pop the head byte when idle, or at the very end of a stop period so
    // the next start bit follows with no idle gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == IDLE)                pop = 1'b1;
            else if (state_q == STOP && stop_end) pop = 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Frame sequencer: baud counter, bit counter and registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    if (pop) begin
                        shreg_q <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^fifo_dout;
`endif
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shreg_q <= {1'b0, shreg_q[7:1]};
                            tx_q    <= shreg_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (stop_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shreg_q <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                            par_q   <= ^fifo_dout;
`endif
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                default: begin
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped write wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= (ovf_q & ~clr_ovf) | (wr_en & fifo_full);
    end

    assign tx_pin = tx_q;
    assign busy   = (state_q != IDLE);
    assign full   = fifo_full;
    assign empty  = fifo_empty;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at 10 clocks/bit, 4-entry FIFO.
// A second instance with two stop bits shares the stimulus.
module tb_mmio_uart_tx;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [31:0] wr_data = '0;

    logic       tx, full, empty, busy, ovf;
    logic [2:0] level;
    logic       tx2, full2, empty2, busy2, ovf2;
    logic [2:0] level2;

    int n_chk = 0;
    int n_fail = 0;

    mmio_uart_tx #(.XLEN(32), .CLK_FRE(1), .BAUD_RATE(100000),
                   .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .tx_pin(tx), .full(full), .empty(empty),
        .level(level), .busy(busy), .ovf(ovf));

    mmio_uart_tx #(.XLEN(32), .CLK_FRE(1), .BAUD_RATE(100000),
                   .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .tx_pin(tx2), .full(full2), .empty(empty2),
        .level(level2), .busy(busy2), .ovf(ovf2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot idx of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0)                 return 1'b0;
        if (idx <= 8)                 return b[idx-1];
        if (PAR == 1 && idx == 9)     return ^b;
        return 1'b1;
    endfunction

    // Check every cycle of a frame from cycle k0 on; leaves the bench at the
    // first cycle after the frame.
    task automatic check_frame(input int dut, input logic [7:0] b, input int nstop,
                               input int k0, input string tag);
        int nb;
        nb = 1 + 8 + PAR + nstop;
        for (int k = k0; k < nb * CPB; k++) begin
            chk($sformatf("%s_tx_k%0d", tag, k), 32'(dut == 1 ? tx2 : tx), 32'(exp_bit(b, k / CPB)));
            chk($sformatf("%s_busy_k%0d", tag, k), 32'(dut == 1 ? busy2 : busy), 32'd1);
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"}, 32'(tx), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_level"}, 32'(level), 32'd0);
    endtask

    task automatic write(input logic [7:0] b);
        wr_data = {24'hDEADBE, b};
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state, both during and after reset.
        tick();
        tick();
        check_idle("rst_hold");
        chk("rst_hold_full", 32'(full), 32'd0);
        chk("rst_hold_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();
        check_idle("rst_rel");
        chk("rst_rel_ovf", 32'(ovf), 32'd0);

        // Single byte 0x55; start bit two cycles after the strobe.
        write(8'h55);
        chk("w55_level", 32'(level), 32'd1);
        chk("w55_tx_pre", 32'(tx), 32'd1);
        wr_data = 32'hFFFF_FFAA;
        tick();
        chk("w55_level_pop", 32'(level), 32'd0);
        check_frame(0, 8'h55, 1, 0, "w55");
        check_idle("w55_after");

        // Overflow: six consecutive writes, fifth stored, sixth dropped.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_data = 32'h10 + 32'(i);
            wr_en   = 1'b1;
            tick();
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_level", 32'(level), 32'd4);
        clr_ovf = 1'b1;
        tick();
        chk("ovf_clr_vs_new", 32'(ovf), 32'd1);
        wr_en = 1'b0;
        tick();
        chk("ovf_cleared", 32'(ovf), 32'd0);
        chk("ovf_level_hold", 32'(level), 32'd4);
        clr_ovf = 1'b0;
        check_frame(0, 8'h10, 1, 6, "ovf_f0");
        check_frame(0, 8'h11, 1, 0, "ovf_f1");
        check_frame(0, 8'h12, 1, 0, "ovf_f2");
        check_frame(0, 8'h13, 1, 0, "ovf_f3");
        check_frame(0, 8'h14, 1, 0, "ovf_f4");
        check_idle("ovf_after");

        // Three queued bytes go out back-to-back.
        do_reset();
        write(8'hA1);
        write(8'hB2);
        write(8'hC3);
        chk("b2b_level", 32'(level), 32'd2);
        check_frame(0, 8'hA1, 1, 1, "b2b_f0");
        chk("b2b_empty_f1", 32'(empty), 32'd0);
        check_frame(0, 8'hB2, 1, 0, "b2b_f1");
        chk("b2b_empty_f2", 32'(empty), 32'd1);
        check_frame(0, 8'hC3, 1, 0, "b2b_f2");
        check_idle("b2b_after");

        // Reset mid-frame discards the frame and the queued byte.
        do_reset();
        write(8'hA5);
        write(8'h5A);
        chk("rmid_level", 32'(level), 32'd1);
        for (int k = 0; k < 35; k++) tick();
        chk("rmid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_idle("rmid_async");
        tick();
        rst = 1'b0;
        tick();
        write(8'h3C);
        tick();
        check_frame(0, 8'h3C, 1, 0, "rmid_post");
        check_idle("rmid_after");
        tick();
        check_idle("rmid_after2");

        // 0x07: parity bit is 1 when the parity build is used.
        do_reset();
        write(8'h07);
        tick();
        check_frame(0, 8'h07, 1, 0, "par07");
        check_idle("par07_after");

        // Two stop bits: 0xFF twice, stop period 20 cycles before next start.
        do_reset();
        write(8'hFF);
        write(8'hFF);
        chk("sb2_level", 32'(level2), 32'd1);
        check_frame(1, 8'hFF, 2, 0, "sb2_f0");
        chk("sb2_empty", 32'(empty2), 32'd1);
        check_frame(1, 8'hFF, 2, 0, "sb2_f1");
        chk("sb2_idle_tx", 32'(tx2), 32'd1);
        chk("sb2_idle_busy", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
